// File: rtl/prewish5k_pkg.sv
// prewish5k_pkg: shared defaults and output FSM encoding for the mask loader
package prewish5k_pkg;
   localparam int DEB_BITS_DEF   = 16;
   localparam int DEPTH_LOG2_DEF = 2;
   typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_e;
endpackage

// File: rtl/prewish5k_maskload_deb.sv
// prewish5k_maskload_deb: stability-counter debouncer for an already synchronized input
module prewish5k_maskload_deb
   import prewish5k_pkg::*;
#(
   parameter int DEB_BITS = DEB_BITS_DEF
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic in_i,
   output logic state_o
);
   logic [DEB_BITS-1:0] cnt_q, cnt_d;
   logic                state_q, state_d;
   always_comb begin
      cnt_d   = (in_i == state_q || &cnt_q) ? '0 : cnt_q + 1'b1;
      state_d = (in_i != state_q && &cnt_q) ? in_i : state_q;
   end
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         cnt_q   <= '0;
         state_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         state_q <= state_d;
      end
   assign state_o = state_q;
endmodule

// File: rtl/prewish5k_maskload.sv
// prewish5k_maskload: debounced button presses queue inverted DIP masks,
// presented downstream one at a time over a STB_O/ACK_I handshake
module prewish5k_maskload
   import prewish5k_pkg::*;
#(
   parameter int DEB_BITS   = DEB_BITS_DEF,
   parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
   parameter int ALIVE_BITS = 22
) (
   input  logic       CLK_I,
   input  logic       RST_I,
   input  logic       i_button,
   input  logic [7:0] i_dip,
   output logic       STB_O,
   output logic [7:0] DAT_O,
   input  logic       ACK_I,
   output logic       o_overflow,
   output logic       o_alive
);
   logic [1:0]            btn_sync_q;
   logic [7:0]            dip_meta_q, dip_sync_q;
   logic                  deb, deb_prev_q, press_q, ovf_q, ovf_d;
   logic [DEPTH_LOG2:0]   wp_q, wp_d, rp_q, rp_d;
   logic [7:0]            mem_q [2**DEPTH_LOG2];
   logic [7:0]            dat_q, dat_d;
   logic [ALIVE_BITS-1:0] alive_q;
   logic                  empty, full, pop, push;
   state_e                state_q, state_d;

   prewish5k_maskload_deb #(.DEB_BITS(DEB_BITS)) u_deb (
      .clk_i  (CLK_I),
      .rst_ni (RST_I),
      .in_i   (btn_sync_q[1]),
      .state_o(deb)
   );

   assign empty = wp_q == rp_q;
   assign full  = (wp_q[DEPTH_LOG2] != rp_q[DEPTH_LOG2]) &&
                  (wp_q[DEPTH_LOG2-1:0] == rp_q[DEPTH_LOG2-1:0]);

   // A full FIFO still accepts a press when the head leaves in the same cycle;
   // the head already sits in dat_q, so overwriting its slot is harmless.
   always_comb begin
      pop     = (state_q == PRESENT) && ACK_I;
      push    = press_q && (!full || pop);
      ovf_d   = press_q && full && !pop;
      wp_d    = push ? wp_q + 1'b1 : wp_q;
      rp_d    = pop ? rp_q + 1'b1 : rp_q;
      state_d = (state_q == IDLE) ? (empty ? IDLE : PRESENT) : (ACK_I ? IDLE : PRESENT);
      dat_d   = (state_q == IDLE && !empty) ? mem_q[rp_q[DEPTH_LOG2-1:0]] : dat_q;
   end

   always_ff @(posedge CLK_I or negedge RST_I)
      if (!RST_I) begin
         btn_sync_q <= '0;
         dip_meta_q <= '0;
         dip_sync_q <= '0;
         deb_prev_q <= 1'b0;
         press_q    <= 1'b0;
         wp_q       <= '0;
         rp_q       <= '0;
         state_q    <= IDLE;
         dat_q      <= '0;
         ovf_q      <= 1'b0;
         alive_q    <= '0;
      end else begin
         btn_sync_q <= {btn_sync_q[0], i_button};
         dip_meta_q <= i_dip;
         dip_sync_q <= dip_meta_q;
         deb_prev_q <= deb;
         press_q    <= deb & ~deb_prev_q;
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         state_q    <= state_d;
         dat_q      <= dat_d;
         ovf_q      <= ovf_d;
         alive_q    <= alive_q + 1'b1;
      end

   always_ff @(posedge CLK_I)
      if (push) mem_q[wp_q[DEPTH_LOG2-1:0]] <= ~dip_sync_q;

   assign STB_O      = state_q == PRESENT;
   assign DAT_O      = dat_q;
   assign o_overflow = ovf_q;
   assign o_alive    = alive_q[ALIVE_BITS-1];
endmodule

// File: tb/tb_prewish5k_maskload.sv
// tb_prewish5k_maskload: scoreboard bench for the mask loader with a short debounce
module tb_prewish5k_maskload;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_button = 1'b0;
   logic [7:0] i_dip = 8'h00;
   logic       ack = 1'b0;
   logic       stb, ovf, alive;
   logic [7:0] dat;
   logic [7:0] sb [$];
   int         n_tests = 0, n_fail = 0, n_stb = 0, n_ovf = 0;
   logic       stb_prev = 1'b0, ack_prev = 1'b0;
   logic [7:0] dat_prev = 8'h00;

   prewish5k_maskload #(.DEB_BITS(3), .DEPTH_LOG2(2)) dut (
      .CLK_I     (clk),
      .RST_I     (rst_n),
      .i_button  (i_button),
      .i_dip     (i_dip),
      .STB_O     (stb),
      .DAT_O     (dat),
      .ACK_I     (ack),
      .o_overflow(ovf),
      .o_alive   (alive)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input logic [7:0] d, input bit store);
      i_dip = d;
      if (store) sb.push_back(~d);
      i_button = 1'b1;
      tick(20);
      i_button = 1'b0;
      tick(20);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 200 && (sb.size() != 0 || stb); i++) tick(1);
      check(tag, sb.size(), 0);
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         stb_prev = 1'b0;
         ack_prev = 1'b0;
      end else begin
         if (stb_prev && ack_prev) check("stb_gap", stb, 0);
         if (stb_prev && !ack_prev && stb) check("dat_hold", dat, dat_prev);
         if (stb && !stb_prev) n_stb++;
         if (ovf) n_ovf++;
         if (stb && ack) begin
            if (sb.size() == 0) check("spurious_stb", dat, 32'hDEAD);
            else check("dat", dat, sb.pop_front());
         end
         stb_prev = stb;
         ack_prev = ack;
         dat_prev = dat;
      end
   end

   initial begin
      int s0, o0;
      bit seen;
      tick(3);
      check("rst_stb", stb, 0);
      check("rst_dat", dat, 0);
      check("rst_ovf", ovf, 0);
      check("rst_alive", alive, 0);
      rst_n = 1'b1;
      tick(5);

      ack = 1'b1;
      s0 = n_stb; o0 = n_ovf;
      press(8'hA5, 1'b1);
      drain("single_drain");
      check("single_stb", n_stb - s0, 1);
      check("single_ovf", n_ovf - o0, 0);

      s0 = n_stb;
      i_dip = 8'h3C;
      sb.push_back(8'hC3);
      for (int i = 0; i < 10; i++) begin
         i_button = ~i_button;
         tick(3);
      end
      i_button = 1'b1;
      tick(20);
      i_button = 1'b0;
      tick(20);
      drain("bounce_drain");
      check("bounce_stb", n_stb - s0, 1);

      ack = 1'b0;
      o0 = n_ovf;
      for (int i = 1; i <= 5; i++) press(8'(i), i < 5);
      check("bp_stb", stb, 1);
      check("bp_dat", dat, 8'hFE);
      check("bp_ovf", n_ovf - o0, 1);
      ack = 1'b1;
      drain("bp_drain");

      ack = 1'b0;
      o0 = n_ovf;
      for (int i = 1; i <= 4; i++) press(8'(i), 1'b1);
      i_dip = 8'h06;
      sb.push_back(8'hF9);
      i_button = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick(1);
         seen = dut.press_q;
      end
      check("sim_press_seen", seen, 1);
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      tick(19);
      i_button = 1'b0;
      tick(20);
      check("sim_ovf", n_ovf - o0, 0);
      ack = 1'b1;
      drain("sim_drain");

      ack = 1'b0;
      press(8'h10, 1'b1);
      press(8'h20, 1'b1);
      press(8'h30, 1'b1);
      check("mid_stb_pre", stb, 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_stb_async", stb, 0);
      check("mid_dat_async", dat, 0);
      sb.delete();
      tick(3);
      rst_n = 1'b1;
      ack = 1'b1;
      s0 = n_stb;
      tick(40);
      check("mid_no_stb", n_stb - s0, 0);
      press(8'h77, 1'b1);
      drain("mid_new_press");

      s0 = n_stb;
      rst_n = 1'b0;
      i_dip = 8'h0F;
      i_button = 1'b1;
      sb.push_back(8'hF0);
      tick(2);
      rst_n = 1'b1;
      tick(40);
      i_button = 1'b0;
      tick(20);
      drain("held_drain");
      check("held_stb", n_stb - s0, 1);

      o0 = n_ovf;
      s0 = n_stb;
      for (int i = 0; i < 12; i++) press(8'($urandom_range(0, 255)), 1'b1);
      drain("wrap_drain");
      check("wrap_stb", n_stb - s0, 12);
      check("wrap_ovf", n_ovf - o0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/prewish5k_maskload.md
PREWISH5K_MASKLOAD -- requirements
Module: prewish5k_maskload

Interface
REQ-001 SHALL have parameter DEB_BITS, default 16: button stability counter width; the debounced state changes after 2^DEB_BITS consecutive cycles of a differing synchronized input.
REQ-002 SHALL have parameter DEPTH_LOG2, default 2: the mask FIFO holds 2^DEPTH_LOG2 entries.
REQ-003 SHALL have parameter ALIVE_BITS, default 22: alive counter width.
REQ-004 SHALL have port CLK_I  input  1: the single clock; all state SHALL be on its rising edge.
REQ-005 SHALL have port RST_I  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port i_button  input  1: raw button, active-high, asynchronous to CLK_I.
REQ-007 SHALL have port i_dip  input  8: raw DIP switches, active-low, asynchronous to CLK_I.
REQ-008 SHALL have port STB_O  output  1: mask-valid strobe to the downstream mentor.
REQ-009 SHALL have port DAT_O  output  8: the mask, active-high.
REQ-010 SHALL have port ACK_I  input  1: downstream accept.
REQ-011 SHALL have port o_overflow  output  1: one-cycle pulse when a press is dropped.
REQ-012 SHALL have port o_alive  output  1: MSB of a free-running ALIVE_BITS counter.

Function
REQ-013 i_button and all i_dip bits SHALL each pass through a 2-flop synchronizer before any other use.
REQ-014 Button debounce: the counter SHALL clear whenever the synchronized button equals the debounced state, and increment otherwise.
REQ-015 Button debounce: when the counter is all-ones and the inputs still differ, the debounced state SHALL take the synchronized value and the counter SHALL clear.
REQ-016 The DIP inputs SHALL be synchronized only, not debounced, and inverted to active-high.
REQ-017 A press event SHALL be a debounced 0->1 transition, registered one cycle after the debounced state changes.
REQ-018 On a press event, the inverted synchronized DIP value in that cycle SHALL be written into the FIFO.
REQ-019 A press event SHALL be written if the FIFO is not full, or if a pop occurs in the same cycle.
REQ-020 If the FIFO is full and there is no pop in that cycle, the press SHALL be dropped and o_overflow SHALL pulse high for exactly one cycle.
REQ-021 Debounced 1->0 transitions (releases) SHALL produce no action.
REQ-022 FIFO read and write pointers SHALL be DEPTH_LOG2+1 bits wide and wrap modulo 2^(DEPTH_LOG2+1).
REQ-023 FIFO empty SHALL be defined as pointers equal; full SHALL be defined as MSBs differing with the remaining bits equal.
REQ-024 The output FSM SHALL have two states: IDLE (STB_O=0) and PRESENT (STB_O=1).
REQ-025 IDLE -> PRESENT SHALL occur when the FIFO is not empty; the head entry SHALL be registered onto DAT_O in the same transition.
REQ-026 In PRESENT, DAT_O and STB_O SHALL remain stable until ACK_I is sampled high.
REQ-027 On ACK_I sampled high in PRESENT, the FSM SHALL pop the FIFO and go to IDLE, so STB_O is low for at least one cycle between masks.
REQ-028 ACK_I SHALL be ignored in IDLE.
REQ-029 Latency: with an empty FIFO in IDLE, STB_O SHALL rise 2 cycles after the press-event cycle (write at N+1, STB_O at N+2).
REQ-030 DAT_O SHALL hold its last value while in IDLE.

Reset
REQ-031 Asserting RST_I low SHALL immediately clear, regardless of current activity: synchronizers, debounced state (0), debounce counter, FIFO pointers, FSM (IDLE), STB_O=0, DAT_O=0, o_overflow=0, and the alive counter.
REQ-032 Reset SHALL discard any in-flight mask with no STB_O glitch.
REQ-033 After RST_I deasserts, a button already held high SHALL produce exactly one press event once the debounce completes.

Structure
REQ-034 The FSM state encodings and the default DEB_BITS and DEPTH_LOG2 values SHALL reside in a shared package, prewish5k_pkg.
REQ-035 The debouncer SHALL be a separate sub-module, prewish5k_maskload_deb, parameterized by DEB_BITS; the FIFO and FSM SHALL be inline.

Verification (DEB_BITS=3, DEPTH_LOG2=2)
REQ-036 Single press: i_dip=8'hA5, i_button held high 20 cycles, ACK_I tied high -> STB_O high with DAT_O=8'h5A for exactly 1 cycle; no o_overflow.
REQ-037 Bounce: i_button toggled every 3 cycles for 30 cycles, then held high -> exactly one STB_O assertion.
REQ-038 Backpressure: ACK_I=0, 5 clean presses with dips 01..05 -> STB_O stays high with DAT_O=8'hFE; one o_overflow pulse on the 5th press; after releasing ACK_I, DAT_O sequence is FE, FD, FC, FB.
REQ-039 Simultaneous full, push and pop: FIFO full, press event in the same cycle as ACK_I accept -> press stored, no o_overflow.
REQ-040 Reset mid-operation: RST_I low while STB_O=1 with 2 entries queued -> STB_O=0 asynchronously; no strobe after release until a new press.
REQ-041 Pointer wrap: 12 press/ack cycles -> DAT_O matches the dips in order; o_overflow never asserts.
